// File: rtl/alu_sched_pkg.sv
// Shared definitions for alu_scheduler: FSM state encoding, unit select codes
// and the bit positions of the unit/function fields inside a 4-bit op.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam int OP_UNIT_HI = 3;
  localparam int OP_UNIT_LO = 2;
  localparam int OP_FUNC_HI = 1;
  localparam int OP_FUNC_LO = 0;

  // Unit code -> one-hot enable vector, bit index equals the unit code.
  function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
    return 4'b0001 << unit;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: when both request, the one not granted last
// wins. Purely combinational; the last-granted state lives in the caller.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester ALU scheduler: IDLE -> ISSUE -> WAIT -> RESP per operation.
// Define ALU_SCHED_TIMEOUT_EN to bound the WAIT dwell to timeout_cycles.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int in_width       = 16,
  parameter int out_width      = 16,
  parameter int timeout_cycles = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic                       req1_valid,
  output logic                       req0_ready,
  output logic                       req1_ready,
  input  logic signed [in_width-1:0] req0_a,
  input  logic signed [in_width-1:0] req0_b,
  input  logic signed [in_width-1:0] req1_a,
  input  logic signed [in_width-1:0] req1_b,
  input  logic [3:0]                 req0_op,
  input  logic [3:0]                 req1_op,
  output logic [in_width-1:0]        alu_a,
  output logic [in_width-1:0]        alu_b,
  output logic                       arith_enable,
  output logic                       logic_enable,
  output logic                       cmp_enable,
  output logic                       shift_enable,
  output logic [1:0]                 alu_func,
  input  logic [out_width-1:0]       alu_out,
  input  logic                       alu_flag,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [out_width-1:0]       rsp_data,
  output logic                       rsp_err,
  input  logic                       rsp_ready
);

  state_t               r_state;
  logic                 r_last;
  logic                 r_id;
  logic [in_width-1:0]  r_alu_a;
  logic [in_width-1:0]  r_alu_b;
  logic [3:0]           r_en;
  logic [1:0]           r_func;
  logic                 r_rsp_valid;
  logic [out_width-1:0] r_rsp_data;

  logic [1:0]           w_grant;
  logic [3:0]           w_op;

  rr_arb2 u_arb (
    .i_req   ({req1_valid, req0_valid}),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_op = w_grant[1] ? req1_op : req0_op;

  // Ready must coincide with the accepting cycle, so it is decoded from state.
  assign req0_ready = (r_state == ST_IDLE) && w_grant[0];
  assign req1_ready = (r_state == ST_IDLE) && w_grant[1];

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(timeout_cycles + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_en        <= '0;
      r_func      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      // Enables and function code are one-cycle pulses during ISSUE.
      r_en   <= '0;
      r_func <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_id    <= w_grant[1];
            r_alu_a <= w_grant[1] ? req1_a : req0_a;
            r_alu_b <= w_grant[1] ? req1_b : req0_b;
            r_en    <= unit_onehot(w_op[OP_UNIT_HI:OP_UNIT_LO]);
            r_func  <= w_op[OP_FUNC_HI:OP_FUNC_LO];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef ALU_SCHED_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_flag) begin
            r_rsp_data  <= alu_out;
            r_rsp_valid <= 1'b1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= ST_RESP;
          end
`ifdef ALU_SCHED_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(timeout_cycles - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_last      <= r_id;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign arith_enable = r_en[UNIT_ARITH];
  assign logic_enable = r_en[UNIT_LOGIC];
  assign cmp_enable   = r_en[UNIT_CMP];
  assign shift_enable = r_en[UNIT_SHIFT];
  assign alu_func     = r_func;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_id;
  assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler; the bench itself plays the ALU units,
// answering each issue with a table-supplied result one cycle later.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] alu_a, alu_b;
  logic        arith_enable, logic_enable, cmp_enable, shift_enable;
  logic [1:0]  alu_func;
  logic [15:0] alu_out;
  logic        alu_flag;
  logic        rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [15:0] rsp_data;

  logic [3:0]  en_vec;
  logic [1:0]  rdy_vec;
  assign en_vec  = {shift_enable, cmp_enable, logic_enable, arith_enable};
  assign rdy_vec = {req1_ready, req0_ready};

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .arith_enable(arith_enable), .logic_enable(logic_enable),
    .cmp_enable(cmp_enable), .shift_enable(shift_enable),
    .alu_func(alu_func), .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  typedef struct {
    logic        idx;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ret;
    logic [3:0]  en;
    logic [1:0]  func;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // IDLE cycle: raise the requester's valid and check that only it is granted.
  task automatic accept(input logic idx, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic keep, input string name);
    if (idx) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    @(negedge clk);
    chk({name, " ready"}, {30'd0, rdy_vec}, idx ? 32'd2 : 32'd1);
    step;
    if (!keep) begin
      if (idx) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
  endtask

  // ISSUE, WAIT, optional RESP stall, then the RESP handshake back to IDLE.
  task automatic finish(input vec_t v, input int stall, input string name);
    @(negedge clk);
    chk({name, " issue en"}, {28'd0, en_vec}, {28'd0, v.en});
    chk({name, " issue func"}, {30'd0, alu_func}, {30'd0, v.func});
    chk({name, " issue a"}, {16'd0, alu_a}, {16'd0, v.a});
    chk({name, " issue b"}, {16'd0, alu_b}, {16'd0, v.b});
    chk({name, " issue rdy"}, {30'd0, rdy_vec}, 32'd0);
    step;
    alu_flag = 1'b1; alu_out = v.ret;
    @(negedge clk);
    chk({name, " wait en"}, {28'd0, en_vec}, 32'd0);
    chk({name, " wait a"}, {16'd0, alu_a}, {16'd0, v.a});
    chk({name, " wait rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({name, " wait rdy"}, {30'd0, rdy_vec}, 32'd0);
    step;
    alu_flag = 1'b0; alu_out = 16'd0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({name, " stall valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({name, " stall data"}, {16'd0, rsp_data}, {16'd0, v.ret});
      chk({name, " stall rdy"}, {30'd0, rdy_vec}, 32'd0);
      step;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({name, " rsp valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, " rsp id"}, {31'd0, rsp_id}, {31'd0, v.idx});
    chk({name, " rsp data"}, {16'd0, rsp_data}, {16'd0, v.ret});
    chk({name, " rsp err"}, {31'd0, rsp_err}, 32'd0);
    chk({name, " rsp alu_a"}, {16'd0, alu_a}, 32'd0);
    step;
    rsp_ready = 1'b0;
    $display("txn %s: id=%0d op=%b a=%h b=%h data=%h", name, v.idx, v.op, v.a, v.b, v.ret);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, " alu_a"}, {16'd0, alu_a}, 32'd0);
    chk({name, " alu_b"}, {16'd0, alu_b}, 32'd0);
    chk({name, " en"}, {28'd0, en_vec}, 32'd0);
    chk({name, " func"}, {30'd0, alu_func}, 32'd0);
    chk({name, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({name, " rsp_data"}, {16'd0, rsp_data}, 32'd0);
    chk({name, " rdy"}, {30'd0, rdy_vec}, 32'd0);
  endtask

  vec_t v;

  initial begin
    tbl[0] = '{1'b0, 4'b0100, 16'h00F0, 16'h0FF0, 16'h00F0, 4'b0010, 2'd0};
    tbl[1] = '{1'b1, 4'b0001, 16'h0003, 16'h0004, 16'h0007, 4'b0001, 2'd1};
    tbl[2] = '{1'b0, 4'b1010, 16'hFFFF, 16'h0001, 16'h0001, 4'b0100, 2'd2};
    tbl[3] = '{1'b1, 4'b1111, 16'h8000, 16'h0003, 16'hF000, 4'b1000, 2'd3};

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_op = 0; req1_op = 0;
    alu_out = 0; alu_flag = 0; rsp_ready = 0;
    step; step;
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    step;
    rst = 1'b0;

    // Each unit select with its own function code.
    for (int i = 0; i < 4; i++) begin
      accept(tbl[i].idx, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, $sformatf("vec%0d", i));
      finish(tbl[i], 0, $sformatf("vec%0d", i));
    end

    // Round robin with both requesters permanently valid.
    rst = 1'b1; step; rst = 1'b0;
    req0_op = 4'b0000; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_op = 4'b1001; req1_a = 16'h0003; req1_b = 16'h0004;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v.idx = k[0];
      v.op  = k[0] ? 4'b1001 : 4'b0000;
      v.a   = k[0] ? 16'h0003 : 16'h0001;
      v.b   = k[0] ? 16'h0004 : 16'h0002;
      v.ret = 16'h0A00 + 16'(k);
      v.en  = k[0] ? 4'b0100 : 4'b0001;
      v.func = k[0] ? 2'd1 : 2'd0;
      accept(v.idx, v.op, v.a, v.b, 1'b1, $sformatf("rr%0d", k));
      finish(v, 0, $sformatf("rr%0d", k));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // RESP back-pressure for 5 cycles while requester 1 waits.
    v = '{1'b0, 4'b0110, 16'h1234, 16'h5678, 16'hBEEF, 4'b0010, 2'd2};
    accept(1'b0, v.op, v.a, v.b, 1'b0, "stall");
    req1_valid = 1'b1; req1_op = 4'b0011; req1_a = 16'h0010; req1_b = 16'h0020;
    finish(v, 5, "stall");
    v = '{1'b1, 4'b0011, 16'h0010, 16'h0020, 16'h0030, 4'b0001, 2'd3};
    accept(1'b1, v.op, v.a, v.b, 1'b0, "after_stall");
    finish(v, 0, "after_stall");

    // Reset in WAIT: no response, pointer back to requester 0.
    v = '{1'b0, 4'b0000, 16'h0005, 16'h0006, 16'h000B, 4'b0001, 2'd0};
    accept(1'b0, v.op, v.a, v.b, 1'b0, "pre_rst");
    finish(v, 0, "pre_rst");
    accept(1'b0, 4'b1100, 16'h7777, 16'h0001, 1'b0, "rst_wait");
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_wait en", {28'd0, en_vec}, 32'd0);
    chk("rst_wait rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wait rsp_data", {16'd0, rsp_data}, 32'd0);
    step;
    req1_valid = 1'b1; req1_op = 4'b0101; req1_a = 16'h0009; req1_b = 16'h0009;
    v = '{1'b0, 4'b0000, 16'h0002, 16'h0003, 16'h0005, 4'b0001, 2'd0};
    accept(1'b0, v.op, v.a, v.b, 1'b0, "post_rst");
    req1_valid = 1'b0;
    finish(v, 0, "post_rst");

`ifdef ALU_SCHED_TIMEOUT_EN
    accept(1'b0, 4'b0100, 16'h4444, 16'h1111, 1'b0, "timeout");
    step;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      chk("timeout wait valid", {31'd0, rsp_valid}, 32'd0);
      step;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("timeout rsp valid", {31'd0, rsp_valid}, 32'd1);
    chk("timeout rsp err", {31'd0, rsp_err}, 32'd1);
    chk("timeout rsp data", {16'd0, rsp_data}, 32'd0);
    step;
    rsp_ready = 1'b0;
    $display("txn timeout: err=1 data=0");
`else
    accept(1'b0, 4'b0100, 16'h4444, 16'h1111, 1'b0, "longwait");
    step;
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      chk("longwait valid", {31'd0, rsp_valid}, 32'd0);
      chk("longwait alu_a", {16'd0, alu_a}, 32'h4444);
      step;
    end
    alu_flag = 1'b1; alu_out = 16'h55AA;
    step;
    alu_flag = 1'b0; alu_out = 16'h0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("longwait rsp valid", {31'd0, rsp_valid}, 32'd1);
    chk("longwait rsp data", {16'd0, rsp_data}, 32'h55AA);
    chk("longwait rsp err", {31'd0, rsp_err}, 32'd0);
    step;
    rsp_ready = 1'b0;
    $display("txn longwait: data=55aa after 12 wait cycles");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter in_width, default 16, operand width of each requester and of the ALU operand bus.
REQ-002 Parameter out_width, default 16, ALU result width and response data width.
REQ-003 Parameter timeout_cycles, default 8, maximum WAIT dwell when ALU_SCHED_TIMEOUT_EN is defined.
REQ-004 Clock is clk; reset is rst, synchronous and active-high.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-008 req0_ready, req1_ready  output  1 each  requester's operation accepted this cycle.
REQ-009 req0_a, req0_b, req1_a, req1_b  input  in_width, signed  operands.
REQ-010 req0_op, req1_op  input  4  op[3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), op[1:0] unit function.
REQ-011 alu_a, alu_b  output  in_width  operands driven to all units.
REQ-012 arith_enable, logic_enable, cmp_enable, shift_enable  output  1 each  unit enables.
REQ-013 alu_func  output  2  function code to the selected unit.
REQ-014 alu_out  input  out_width  OR of unit registered results; alu_flag  input  1  OR of unit registered flags.
REQ-015 rsp_valid  output  1; rsp_id  output  1 (requester index); rsp_data  output  out_width; rsp_err  output  1.
REQ-016 rsp_ready  input  1  response consumer accepts.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req valid, grant one, assert its ready for exactly that cycle, capture a, b, op, id; go ISSUE; else stay.
REQ-019 Both valid in IDLE: grant the requester not granted last; after reset requester 0 has priority; only one ready high per cycle.
REQ-020 ISSUE: exactly one enable high (per op[3:2]) for exactly one cycle with alu_func=op[1:0]; go WAIT.
REQ-021 alu_a/alu_b SHALL hold captured operands from ISSUE through WAIT; zero in IDLE and RESP.
REQ-022 WAIT: all enables low; when alu_flag=1 capture alu_out into rsp_data, rsp_err=0, go RESP; else stay.
REQ-023 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err stable until rsp_ready=1; then update last-granted to rsp_id and go IDLE.
REQ-024 Minimum latency: accept at cycle N, rsp_valid at N+3; peak throughput one op per 4 cycles.
REQ-025 ready SHALL never assert outside IDLE; requests arriving in other states wait.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, all outputs 0, rsp_data 0, last-granted pointer to favour requester 0, timeout counter 0.
REQ-027 Reset during ISSUE, WAIT or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-028 Macro ALU_SCHED_TIMEOUT_EN defined: a counter cleared on WAIT entry increments each WAIT cycle; reaching timeout_cycles without alu_flag forces RESP with rsp_data=0, rsp_err=1.
REQ-029 Macro undefined: no counter, WAIT waits indefinitely, rsp_err tied 0, port retained.

Structure
REQ-030 Shared package alu_sched_pkg SHALL hold the state encoding, unit select codes, and op field bit positions.
REQ-031 Grant logic SHALL be a sub-module rr_arb2 (2-way round-robin, last-granted input, one-hot grant output).

Verification
REQ-032 req0 valid, op=0100, a=0x00F0, b=0x0FF0; logic unit returns flag at N+2 with 0x00F0 -> logic_enable high only at N+1, rsp at N+3, id=0, data=0x00F0.
REQ-033 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; ready never concurrent.
REQ-034 rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, no ready asserted, IDLE one cycle after rsp_ready=1.
REQ-035 rst=1 during WAIT -> next cycle all outputs 0, no response; subsequent simultaneous requests grant requester 0.
REQ-036 With ALU_SCHED_TIMEOUT_EN, timeout_cycles=8, alu_flag held 0 -> rsp_valid with rsp_err=1, data=0, after 8 WAIT cycles.
REQ-037 Each op[3:2] value 00..11 -> exactly the matching enable pulses one cycle, alu_func equals op[1:0].
